// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: opcode/funct codes, ALU operation
// enum and the iterative multiplier state type.
package ex_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO, ALU_MULT
    } alu_op_e;

    typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM signal bundle of the execute stage. master = upstream driver,
// slave = ex_stage.
interface ex_stage_if #(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6
);
    logic                 i_step;
    logic [NB_FCODE-1:0]  i_instruction_funct_code;
    logic [NB_OPCODE-1:0] i_instruction_op_code;
    logic                 i_alu_src;
    logic [NB-1:0]        i_data_a;
    logic [NB-1:0]        i_data_b;
    logic [NB-1:0]        i_extension_result;
    logic [NB-1:0]        o_alu_result;
    logic [NB-1:0]        o_store_data;
    logic                 o_zero;
    logic [NB_OPCODE-1:0] o_instruction_op_code;
    logic                 o_valid;
    logic                 o_busy;

    modport master (
        output i_step, i_instruction_funct_code, i_instruction_op_code, i_alu_src,
               i_data_a, i_data_b, i_extension_result,
        input  o_alu_result, o_store_data, o_zero, o_instruction_op_code, o_valid, o_busy
    );

    modport slave (
        input  i_step, i_instruction_funct_code, i_instruction_op_code, i_alu_src,
               i_data_a, i_data_b, i_extension_result,
        output o_alu_result, o_store_data, o_zero, o_instruction_op_code, o_valid, o_busy
    );
endinterface

// File: rtl/mult_iter.sv
// 32-step shift-add multiplier on magnitudes with final sign fix-up; only built when
// EX_MULT_EN is defined. o_product is the finished result during the o_last step.
`ifdef EX_MULT_EN
module mult_iter
    import ex_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_step,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [NB-1:0]   i_a,
    input  logic [NB-1:0]   i_b,
    output logic            o_busy,
    output logic            o_last,
    output logic [2*NB-1:0] o_product
);
    localparam int CW = $clog2(NB);

    mul_state_e      state;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic [2*NB-1:0] mcand;
    logic [2*NB-1:0] acc;
    logic [2*NB-1:0] acc_sum;
    logic [NB-1:0]   mplier;
    logic [NB-1:0]   mag_a;
    logic [NB-1:0]   mag_b;

    assign mag_a     = (i_signed && i_a[NB-1]) ? -i_a : i_a;
    assign mag_b     = (i_signed && i_b[NB-1]) ? -i_b : i_b;
    assign acc_sum   = mplier[0] ? acc + mcand : acc;
    assign o_product = neg ? -acc_sum : acc_sum;
    assign o_busy    = (state == MUL_RUN);
    assign o_last    = o_busy && (cnt == CW'(NB - 1));

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= MUL_IDLE;
            cnt   <= '0;
            neg   <= 1'b0;
        end else if (i_step) begin
            case (state)
                MUL_IDLE: begin
                    if (i_start) begin
                        state <= MUL_RUN;
                        cnt   <= '0;
                        neg   <= i_signed & (i_a[NB-1] ^ i_b[NB-1]);
                    end
                end
                MUL_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (o_last) state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on start.
    always_ff @(negedge i_clk) begin
        if (i_step) begin
            if (state == MUL_IDLE && i_start) begin
                mcand  <= {{NB{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
            end else if (state == MUL_RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end
endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: decode, operand select, ALU and the EX/MEM register (falling edge).
// EX_MULT_EN adds the iterative MULT/MULTU unit, HI/LO and MFHI/MFLO.
module ex_stage
    import ex_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6
) (
    input logic       i_clk,
    input logic       i_reset_n,
    ex_stage_if.slave bus
);
    localparam int SHW = $clog2(NB);

    alu_op_e              alu_op;
    logic [SHW-1:0]       shamt;
    logic [NB-1:0]        op_b;
    logic [NB-1:0]        alu_res;
    logic                 ld;
    logic [NB-1:0]        nxt_res;
    logic [NB-1:0]        nxt_sd;
    logic [NB_OPCODE-1:0] nxt_op;
    logic                 nxt_vld;
    logic                 nxt_zero;
    logic [NB-1:0]        res_p1;
    logic [NB-1:0]        sd_p1;
    logic [NB_OPCODE-1:0] op_p1;
    logic                 zero_p1;
    logic                 vld_p1;

    function automatic logic [NB-1:0] alu_eval(input alu_op_e op, input logic [NB-1:0] a,
                                               input logic [NB-1:0] b, input logic [NB-1:0] rt,
                                               input logic [NB-1:0] imm, input logic [SHW-1:0] sh);
        logic signed [NB-1:0] sa;
        logic signed [NB-1:0] sb;
        logic signed [NB-1:0] srt;
        logic [NB-1:0]        r;
        sa  = a;
        sb  = b;
        srt = rt;
        r   = '0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? NB'(1) : '0;
            ALU_SLTU: r = (a < b) ? NB'(1) : '0;
            ALU_SLL:  r = rt << sh;
            ALU_SRL:  r = rt >> sh;
            ALU_SRA:  r = srt >>> sh;
            ALU_LUI:  r = {imm[15:0], {(NB-16){1'b0}}};
            default:  r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_op = ALU_NONE;
        shamt  = bus.i_extension_result[6 +: SHW];
        case (bus.i_instruction_op_code)
            OP_RTYPE: begin
                case (bus.i_instruction_funct_code)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; shamt = bus.i_data_a[SHW-1:0]; end
                    FN_SRLV: begin alu_op = ALU_SRL; shamt = bus.i_data_a[SHW-1:0]; end
                    FN_SRAV: begin alu_op = ALU_SRA; shamt = bus.i_data_a[SHW-1:0]; end
`ifdef EX_MULT_EN
                    FN_MULT, FN_MULTU: alu_op = ALU_MULT;
                    FN_MFHI:           alu_op = ALU_MFHI;
                    FN_MFLO:           alu_op = ALU_MFLO;
`endif
                    default:         alu_op = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_SLTI:        alu_op = ALU_SLT;
            OP_SLTIU:       alu_op = ALU_SLTU;
            OP_ANDI:        alu_op = ALU_AND;
            OP_ORI:         alu_op = ALU_OR;
            OP_XORI:        alu_op = ALU_XOR;
            OP_LUI:         alu_op = ALU_LUI;
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            default:        alu_op = ALU_NONE;
        endcase
    end

    // Logical immediates are zero-extended; branches always compare against rt.
    always_comb begin
        case (bus.i_instruction_op_code)
            OP_BEQ, OP_BNE:           op_b = bus.i_data_b;
            OP_ANDI, OP_ORI, OP_XORI: op_b = {{(NB-16){1'b0}}, bus.i_extension_result[15:0]};
            default:                  op_b = bus.i_alu_src ? bus.i_extension_result : bus.i_data_b;
        endcase
    end

`ifdef EX_MULT_EN
    logic [NB-1:0]   hi_q;
    logic [NB-1:0]   lo_q;
    logic            mul_busy;
    logic            mul_last;
    logic [2*NB-1:0] mul_product;

    mult_iter #(.NB(NB)) u_mult (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (bus.i_step),
        .i_start   (alu_op == ALU_MULT),
        .i_signed  (bus.i_instruction_funct_code == FN_MULT),
        .i_a       (bus.i_data_a),
        .i_b       (bus.i_data_b),
        .o_busy    (mul_busy),
        .o_last    (mul_last),
        .o_product (mul_product)
    );

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (bus.i_step && mul_last) begin
            {hi_q, lo_q} <= mul_product;
        end
    end

    assign bus.o_busy = mul_busy;
`else
    assign bus.o_busy = 1'b0;
`endif

    always_comb begin
        alu_res = alu_eval(alu_op, bus.i_data_a, op_b, bus.i_data_b,
                           bus.i_extension_result, shamt);
`ifdef EX_MULT_EN
        if (alu_op == ALU_MFHI)      alu_res = hi_q;
        else if (alu_op == ALU_MFLO) alu_res = lo_q;
`endif
    end

    // Next EX/MEM contents: normal result, MULT start bubble, hold during RUN, retire.
    always_comb begin
        ld      = 1'b1;
        nxt_res = alu_res;
        nxt_sd  = bus.i_data_b;
        nxt_op  = bus.i_instruction_op_code;
        nxt_vld = 1'b1;
`ifdef EX_MULT_EN
        if (mul_last) begin
            nxt_res = '0;
            nxt_sd  = '0;
            nxt_op  = '0;
        end else if (mul_busy) begin
            ld = 1'b0;
        end else if (alu_op == ALU_MULT) begin
            nxt_res = '0;
            nxt_sd  = '0;
            nxt_op  = '0;
            nxt_vld = 1'b0;
        end
`endif
        nxt_zero = nxt_vld && (nxt_res == '0);
    end

    // EX/MEM boundary
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            res_p1  <= '0;
            sd_p1   <= '0;
            op_p1   <= '0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (bus.i_step && ld) begin
            res_p1  <= nxt_res;
            sd_p1   <= nxt_sd;
            op_p1   <= nxt_op;
            zero_p1 <= nxt_zero;
            vld_p1  <= nxt_vld;
        end
    end

    assign bus.o_alu_result          = res_p1;
    assign bus.o_store_data          = sd_p1;
    assign bus.o_instruction_op_code = op_p1;
    assign bus.o_zero                = zero_p1;
    assign bus.o_valid               = vld_p1;
endmodule
